// File: rtl/ram_ex_lfsr8_chk_if.sv
// Handshake and result bundle for the lfsr8 read-back checker.
interface ram_ex_lfsr8_chk_if #(
   parameter int unsigned ERR_W = 16
);
   logic             enable;
   logic             start;
   logic [15:0]      num_words;
   logic             in_valid;
   logic [7:0]       in_data;
   logic             in_ready;
   logic [7:0]       exp_data;
   logic [15:0]      word_cnt;
   logic [ERR_W-1:0] err_cnt;
   logic             err_flag;
   logic [7:0]       first_err_got;
   logic [7:0]       first_err_exp;
   logic             done;

   modport master (
      output enable, start, num_words, in_valid, in_data,
      input  in_ready, exp_data, word_cnt, err_cnt, err_flag,
             first_err_got, first_err_exp, done
   );

   modport slave (
      input  enable, start, num_words, in_valid, in_data,
      output in_ready, exp_data, word_cnt, err_cnt, err_flag,
             first_err_got, first_err_exp, done
   );
endinterface

// File: rtl/ram_ex_lfsr8_chk.sv
// Checks a read-back stream against the lfsr8 pattern (x^8+x^4+x^3+x^2+1).
// Optional self-synchronisation on the first word: define LFSR8_CHK_AUTOSYNC_EN.
module ram_ex_lfsr8_chk #(
   parameter int unsigned SEED  = 32,
   parameter int unsigned ERR_W = 16
) (
   input logic                clk,
   input logic                reset_n,
   ram_ex_lfsr8_chk_if.slave  bus
);

   localparam logic [7:0] SEED8 = SEED[7:0];

`ifdef LFSR8_CHK_AUTOSYNC_EN
   typedef enum logic [1:0] {IDLE, SYNC, CHECK, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
`endif

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6], x[5], x[4], x[3] ^ x[7], x[2] ^ x[7], x[1] ^ x[7], x[0], x[7]};
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       exp_q, exp_d;
   logic [15:0]      wcnt_q, wcnt_d;
   logic [15:0]      nw_q, nw_d;
   logic [ERR_W-1:0] ecnt_q, ecnt_d;
   logic             eflag_q, eflag_d;
   logic [7:0]       fgot_q, fgot_d;
   logic [7:0]       fexp_q, fexp_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic             accept;

   assign accept = bus.in_valid && ready_q;

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      wcnt_d  = wcnt_q;
      nw_d    = nw_q;
      ecnt_d  = ecnt_q;
      eflag_d = eflag_q;
      fgot_d  = fgot_q;
      fexp_d  = fexp_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               exp_d   = SEED8;
               wcnt_d  = '0;
               ecnt_d  = '0;
               eflag_d = 1'b0;
               fgot_d  = '0;
               fexp_d  = '0;
               nw_d    = bus.num_words;
               if (bus.num_words == 16'd0)
                  state_d = DONE;
               else
`ifdef LFSR8_CHK_AUTOSYNC_EN
                  state_d = SYNC;
`else
                  state_d = CHECK;
`endif
            end
         end
`ifdef LFSR8_CHK_AUTOSYNC_EN
         SYNC: begin
            if (accept) begin
               exp_d   = lfsr_next(bus.in_data);
               wcnt_d  = wcnt_q + 16'd1;
               state_d = (nw_q == 16'd1) ? DONE : CHECK;
            end
         end
`endif
         CHECK: begin
            if (accept) begin
               exp_d  = lfsr_next(exp_q);
               wcnt_d = wcnt_q + 16'd1;
               if (bus.in_data != exp_q) begin
                  if (ecnt_q != '1)
                     ecnt_d = ecnt_q + ERR_W'(1);
                  if (!eflag_q) begin
                     eflag_d = 1'b1;
                     fgot_d  = bus.in_data;
                     fexp_d  = exp_q;
                  end
               end
               if (wcnt_q + 16'd1 == nw_q)
                  state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      // enable low dominates everything above, including a same-cycle start
      if (!bus.enable) begin
         state_d = IDLE;
         exp_d   = SEED8;
         wcnt_d  = '0;
         nw_d    = '0;
         ecnt_d  = '0;
         eflag_d = 1'b0;
         fgot_d  = '0;
         fexp_d  = '0;
      end

`ifdef LFSR8_CHK_AUTOSYNC_EN
      ready_d = (state_d == SYNC) || (state_d == CHECK);
`else
      ready_d = (state_d == CHECK);
`endif
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         exp_q   <= SEED8;
         wcnt_q  <= '0;
         nw_q    <= '0;
         ecnt_q  <= '0;
         eflag_q <= 1'b0;
         fgot_q  <= '0;
         fexp_q  <= '0;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         wcnt_q  <= wcnt_d;
         nw_q    <= nw_d;
         ecnt_q  <= ecnt_d;
         eflag_q <= eflag_d;
         fgot_q  <= fgot_d;
         fexp_q  <= fexp_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   assign bus.in_ready      = ready_q;
   assign bus.done          = done_q;
   assign bus.exp_data      = exp_q;
   assign bus.word_cnt      = wcnt_q;
   assign bus.err_cnt       = ecnt_q;
   assign bus.err_flag      = eflag_q;
   assign bus.first_err_got = fgot_q;
   assign bus.first_err_exp = fexp_q;

endmodule

// File: tb/tb_ram_ex_lfsr8_chk.sv
// Directed bench for ram_ex_lfsr8_chk: run-level model checked every cycle plus literal pins.
module tb_ram_ex_lfsr8_chk;

`ifdef LFSR8_CHK_AUTOSYNC_EN
   localparam bit AUTOSYNC = 1'b1;
`else
   localparam bit AUTOSYNC = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic [7:0] wq[$];

   ram_ex_lfsr8_chk_if #(.ERR_W(16)) bus ();

   ram_ex_lfsr8_chk #(.SEED(32), .ERR_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Galois form of the pattern step: shift left, fold the taps when bit 7 falls out
   function automatic logic [7:0] step8(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
   endfunction

   // Run-level model: is the checker taking words, what it expects next, what it has seen
   logic        m_ready = 1'b0, m_done = 1'b0, m_sync = 1'b0, m_flag = 1'b0;
   logic [7:0]  m_exp = 8'h20, m_got = 8'h00, m_fexp = 8'h00;
   int unsigned m_words = 0, m_errs = 0, m_nw = 0;

   task automatic model_clear();
      m_ready = 1'b0; m_done = 1'b0; m_sync = 1'b0; m_flag = 1'b0;
      m_exp = 8'h20; m_got = 8'h00; m_fexp = 8'h00;
      m_words = 0; m_errs = 0; m_nw = 0;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n || !bus.enable) begin
         model_clear();
      end else if (bus.start && !m_ready) begin
         model_clear();
         m_nw = bus.num_words;
         if (m_nw == 0) m_done = 1'b1;
         else begin m_ready = 1'b1; m_sync = AUTOSYNC; end
      end else if (m_ready && bus.in_valid) begin
         if (m_sync) begin
            m_exp  = step8(bus.in_data);
            m_sync = 1'b0;
         end else begin
            if (bus.in_data != m_exp) begin
               if (m_errs < 65535) m_errs++;
               if (!m_flag) begin m_flag = 1'b1; m_got = bus.in_data; m_fexp = m_exp; end
            end
            m_exp = step8(m_exp);
         end
         m_words++;
         if (m_words == m_nw) begin m_ready = 1'b0; m_done = 1'b1; end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_ready));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("exp_data", 32'(bus.exp_data), 32'(m_exp));
      chk("word_cnt", 32'(bus.word_cnt), m_words);
      chk("err_cnt", 32'(bus.err_cnt), m_errs);
      chk("err_flag", 32'(bus.err_flag), 32'(m_flag));
      chk("first_err_got", 32'(bus.first_err_got), 32'(m_got));
      chk("first_err_exp", 32'(bus.first_err_exp), 32'(m_fexp));
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start(input logic [15:0] nw);
      bus.start = 1'b1; bus.num_words = nw;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic feed();
      for (int i = 0; i < wq.size(); i++) begin
         bus.in_valid = 1'b1; bus.in_data = wq[i];
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic pin_clean_run(input string tag);
      chk({tag, "_done"}, 32'(bus.done), 32'd1);
      chk({tag, "_words"}, 32'(bus.word_cnt), 32'd5);
      chk({tag, "_errs"}, 32'(bus.err_cnt), 32'd0);
      chk({tag, "_exp"}, 32'(bus.exp_data), 32'h74);
   endtask

   initial begin
      bus.enable = 1'b1; bus.start = 1'b0; bus.num_words = '0;
      bus.in_valid = 1'b0; bus.in_data = '0;
      tick(); tick();
      chk("rst_exp", 32'(bus.exp_data), 32'h20);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      reset_n = 1'b1;
      tick();

      // clean back-to-back run
      pulse_start(16'd5);
      wq = {8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
      feed();
      pin_clean_run("clean");
      tick();

      // third word corrupted
      pulse_start(16'd5);
      wq = {8'h20, 8'h40, 8'h81};
      feed();
      chk("err_exp_cont", 32'(bus.exp_data), 32'h1D);
      wq = {8'h1D, 8'h3A};
      feed();
      chk("err_cnt1", 32'(bus.err_cnt), 32'd1);
      chk("err_flag1", 32'(bus.err_flag), 32'd1);
      chk("err_got", 32'(bus.first_err_got), 32'h81);
      chk("err_fexp", 32'(bus.first_err_exp), 32'h80);
      tick();

      // in_valid 1,0,0,1 pause
      pulse_start(16'd5);
      wq = {8'h20};
      feed();
      tick();
      chk("pause_exp", 32'(bus.exp_data), 32'h40);
      chk("pause_words", 32'(bus.word_cnt), 32'd1);
      tick();
      wq = {8'h40, 8'h80, 8'h1D, 8'h3A};
      feed();
      pin_clean_run("pause");
      tick();

      // enable dropped after two words, with a start in the same cycle
      pulse_start(16'd5);
      wq = {8'h20, 8'h40};
      feed();
      bus.enable = 1'b0; bus.start = 1'b1; bus.num_words = 16'd5;
      tick();
      bus.enable = 1'b1; bus.start = 1'b0;
      chk("en_ready", 32'(bus.in_ready), 32'd0);
      chk("en_words", 32'(bus.word_cnt), 32'd0);
      chk("en_exp", 32'(bus.exp_data), 32'h20);
      pulse_start(16'd5);
      wq = {8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
      feed();
      pin_clean_run("after_en");
      tick();

      // stream that only matches when the checker self-synchronises
      pulse_start(16'd3);
      wq = {8'h80, 8'h1D, 8'h3A};
      feed();
      chk("sync_words", 32'(bus.word_cnt), 32'd3);
      chk("sync_errs", 32'(bus.err_cnt), AUTOSYNC ? 32'd0 : 32'd3);
      tick();

      // zero-length run
      pulse_start(16'd0);
      chk("zero_done", 32'(bus.done), 32'd1);
      chk("zero_ready", 32'(bus.in_ready), 32'd0);
      tick();

      // start during a run is ignored, including its num_words
      pulse_start(16'd5);
      wq = {8'h20, 8'h40};
      feed();
      bus.start = 1'b1; bus.num_words = 16'd2; bus.in_valid = 1'b1; bus.in_data = 8'h80;
      tick();
      bus.start = 1'b0;
      chk("ign_words", 32'(bus.word_cnt), 32'd3);
      wq = {8'h1D, 8'h3A};
      feed();
      pin_clean_run("ignored");
      tick();

      // reset mid-run abandons without done
      pulse_start(16'd5);
      wq = {8'h20, 8'h40};
      feed();
      reset_n = 1'b0;
      #2;
      chk("mrst_words", 32'(bus.word_cnt), 32'd0);
      chk("mrst_done", 32'(bus.done), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("mrst_idle_ready", 32'(bus.in_ready), 32'd0);
      pulse_start(16'd5);
      wq = {8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
      feed();
      pin_clean_run("post_rst");
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
